// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit.
//   size_e     : request size encoding (byte, half, word, reserved)
//   state_e    : control FSM states
//   size_bytes : byte count of a request size (0 for the reserved code)
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        LD0,
        LD1,
        LDW,
        ST0,
        ST1
    } state_e;

    function automatic logic [2:0] size_bytes(input size_e size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mau_align.sv
// Byte-lane alignment for the memory access unit (purely combinational).
// Store side: builds the 8-bit lane mask and the 64-bit shifted store data,
// then presents the lower or upper word half for the current write.
// Load side: shifts the {hi, lo} word pair down by the byte offset, keeps
// the requested number of bytes and sign- or zero-extends the result.
//   off       : byte offset within the first word
//   size      : request size
//   ld_signed : sign-extend byte/half loads
//   st_upper  : select the second (upper) word of a split store
//   st_wdata  : right-justified store data
//   ld_lo/hi  : first and second word of a load
//   st_be     : byte enables for the selected word
//   st_data   : lane-aligned write data for the selected word
//   ld_data   : extended load result
module mau_align
    import mau_pkg::*;
(
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        ld_signed,
    input  logic        st_upper,
    input  logic [31:0] st_wdata,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);

    logic [2:0]  nb;
    logic [7:0]  mask;
    logic [63:0] st_wide;
    logic [31:0] ld_win;

    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        nb      = size_bytes(size);
        mask    = ((8'd1 << nb) - 8'd1) << off;
        st_wide = {32'd0, st_wdata} << {off, 3'b000};
        st_be   = st_upper ? mask[7:4] : mask[3:0];
        st_data = st_upper ? st_wide[63:32] : st_wide[31:0];

        // Only the low word of the shifted pair can hold requested bytes.
        ld_win  = 32'({ld_hi, ld_lo} >> {off, 3'b000});
        case (size)
            SZ_B:    ld_data = {{24{ld_signed & ld_win[7]}}, ld_win[7:0]};
            SZ_H:    ld_data = {{16{ld_signed & ld_win[15]}}, ld_win[15:0]};
            default: ld_data = ld_win;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-enabled register file.
// Accepts byte/half/word requests on a valid/ready handshake, issues
// word-addressed reads and byte-enabled writes, and returns a one-cycle
// response pulse (with error flag and extended load data).
// Optional feature macro: MAU_MISALIGNED_SPLIT_EN
//   defined   : misaligned accesses are allowed; word-crossing ones are
//               split into two word accesses (LD1/ST1 states).
//   undefined : misaligned requests get an error response, no rf access.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_size, req_signed    store flag, size code, load sign-extend
//   req_addr, req_wdata             byte address, right-justified store data
//   rsp_valid, rsp_err, rsp_rdata   response pulse, error flag, load data
//   rf_rd_en, rf_rd_addr, rf_rd_data   register-file read channel
//   rf_wr_en, rf_wr_addr, rf_byte_en, rf_wr_data   register-file write channel
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_signed,
    input  logic [BYTE_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    output logic                       rsp_err,
    output logic [31:0]                rsp_rdata,
    output logic                       rf_rd_en,
    output logic [BYTE_ADDR_WIDTH-3:0] rf_rd_addr,
    input  logic [31:0]                rf_rd_data,
    output logic                       rf_wr_en,
    output logic [BYTE_ADDR_WIDTH-3:0] rf_wr_addr,
    output logic [3:0]                 rf_byte_en,
    output logic [31:0]                rf_wr_data
);

    localparam int WAW = BYTE_ADDR_WIDTH - 2;

    state_e state, state_n;

    // Request buffer
    logic           we_q;
    size_e          size_q;
    logic           signed_q;
    logic [1:0]     off_q;
    logic [WAW-1:0] w0_q;
    logic [31:0]    wdata_q;

    // Registered response
    logic        rsp_valid_q, rsp_valid_n;
    logic        rsp_err_q,   rsp_err_n;
    logic [31:0] rsp_rdata_q, rsp_rdata_n;

    logic        accept;
    logic        reject;
    logic        st_upper;
    logic [31:0] ld_lo, ld_hi;
    logic [3:0]  st_be;
    logic [31:0] st_data, ld_data;

`ifdef MAU_MISALIGNED_SPLIT_EN
    logic [WAW-1:0] w1_q;
    logic           cross_q;
    logic [31:0]    word0_q;
    logic           word0_load;
    logic [2:0]     nb_in;
    logic           cross_in;
`else
    logic           misaligned;
`endif

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

`ifdef MAU_MISALIGNED_SPLIT_EN
    always_comb begin
        nb_in    = size_bytes(size_e'(req_size));
        cross_in = ({2'b00, req_addr[1:0]} + {1'b0, nb_in}) > 4'd4;
    end
    assign reject   = (size_e'(req_size) == SZ_RSV);
    assign st_upper = (state == ST1);
    // A split load has word0 buffered; the word arriving now is the upper one.
    assign ld_lo    = cross_q ? word0_q    : rf_rd_data;
    assign ld_hi    = cross_q ? rf_rd_data : 32'd0;
`else
    always_comb begin
        case (size_e'(req_size))
            SZ_H:    misaligned = req_addr[0];
            SZ_W:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end
    assign reject   = (size_e'(req_size) == SZ_RSV) || misaligned;
    assign st_upper = 1'b0;
    assign ld_lo    = rf_rd_data;
    assign ld_hi    = 32'd0;
`endif

    mau_align u_align (
        .off       (off_q),
        .size      (size_q),
        .ld_signed (signed_q),
        .st_upper  (st_upper),
        .st_wdata  (wdata_q),
        .ld_lo     (ld_lo),
        .ld_hi     (ld_hi),
        .st_be     (st_be),
        .st_data   (st_data),
        .ld_data   (ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        rf_rd_en    = 1'b0;
        rf_rd_addr  = '0;
        rf_wr_en    = 1'b0;
        rf_wr_addr  = '0;
        rf_byte_en  = 4'b0000;
        rf_wr_data  = 32'd0;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = 32'd0;
`ifdef MAU_MISALIGNED_SPLIT_EN
        word0_load  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else if (req_we) begin
                        state_n = ST0;
                    end else begin
                        state_n = LD0;
                    end
                end
            end
            LD0: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = w0_q;
`ifdef MAU_MISALIGNED_SPLIT_EN
                state_n    = cross_q ? LD1 : LDW;
`else
                state_n    = LDW;
`endif
            end
`ifdef MAU_MISALIGNED_SPLIT_EN
            LD1: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = w1_q;
                word0_load = 1'b1;
                state_n    = LDW;
            end
`endif
            LDW: begin
                rsp_valid_n = 1'b1;
                rsp_rdata_n = ld_data;
                state_n     = IDLE;
            end
            ST0: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = w0_q;
                rf_byte_en = st_be;
                rf_wr_data = st_data;
`ifdef MAU_MISALIGNED_SPLIT_EN
                if (cross_q) begin
                    state_n = ST1;
                end else begin
                    rsp_valid_n = 1'b1;
                    state_n     = IDLE;
                end
`else
                rsp_valid_n = 1'b1;
                state_n     = IDLE;
`endif
            end
`ifdef MAU_MISALIGNED_SPLIT_EN
            ST1: begin
                rf_wr_en    = 1'b1;
                rf_wr_addr  = w1_q;
                rf_byte_en  = st_be;
                rf_wr_data  = st_data;
                rsp_valid_n = 1'b1;
                state_n     = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            signed_q    <= 1'b0;
            off_q       <= 2'b00;
            w0_q        <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
`ifdef MAU_MISALIGNED_SPLIT_EN
            w1_q        <= '0;
            cross_q     <= 1'b0;
            word0_q     <= 32'd0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_n;
            rsp_err_q   <= rsp_err_n;
            rsp_rdata_q <= rsp_rdata_n;
            if (accept) begin
                we_q     <= req_we;
                size_q   <= size_e'(req_size);
                signed_q <= req_signed;
                off_q    <= req_addr[1:0];
                w0_q     <= req_addr[BYTE_ADDR_WIDTH-1:2];
                wdata_q  <= req_wdata;
`ifdef MAU_MISALIGNED_SPLIT_EN
                // Wraps naturally to word 0 past the top of the register file.
                w1_q     <= req_addr[BYTE_ADDR_WIDTH-1:2] + 1'b1;
                cross_q  <= cross_in;
`endif
            end
`ifdef MAU_MISALIGNED_SPLIT_EN
            if (word0_load) begin
                word0_q <= rf_rd_data;
            end
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural register-file model.
// Feature-specific scenarios follow MAU_MISALIGNED_SPLIT_EN.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [5:0]  req_addr = 6'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        rf_rd_en;
    logic [3:0]  rf_rd_addr;
    logic [31:0] rf_rd_data = 32'd0;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_addr;
    logic [3:0]  rf_byte_en;
    logic [31:0] rf_wr_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];
    int          nwr, nrd;
    logic [3:0]  wr_addr [4];
    logic [3:0]  wr_be   [4];
    logic [31:0] wr_data [4];
    int          wr_cyc  [4];

    int          lat;
    logic        err;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.BYTE_ADDR_WIDTH(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_byte_en (rf_byte_en),
        .rf_wr_data (rf_wr_data)
    );

    // Register-file model: read data the cycle after rf_rd_en, byte-enabled writes.
    initial for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
        if (rf_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (rf_byte_en[b]) mem[rf_wr_addr][8*b +: 8] <= rf_wr_data[8*b +: 8];
        end
    end

    // Present one request for a single cycle; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [5:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_signed = sgn; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Watch up to 10 cycles after the accepting edge; log writes/reads until rsp.
    // lat stays 0 if no response arrives within the bound.
    task automatic wait_rsp(output int l, output logic e, output logic [31:0] d);
        l = 0; e = 1'b0; d = 32'd0; nwr = 0; nrd = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rf_wr_en) begin
                if (nwr < 4) begin
                    wr_addr[nwr] = rf_wr_addr; wr_be[nwr] = rf_byte_en;
                    wr_data[nwr] = rf_wr_data; wr_cyc[nwr] = i;
                end
                nwr++;
            end
            if (rf_rd_en) nrd++;
            if (rsp_valid) begin
                l = i; e = rsp_err; d = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if ({rsp_valid, rsp_err, rf_rd_en, rf_wr_en} !== 4'b0000) begin errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {rsp_valid, rsp_err, rf_rd_en, rf_wr_en}); end
        checks++; if ({rsp_rdata, rf_wr_data, rf_byte_en} !== 68'd0) begin errors++;
            $display("FAIL reset_data: got %h want 0", {rsp_rdata, rf_wr_data, rf_byte_en}); end
        rst_n = 1'b1;
    endtask

    task automatic test_store_word;
        issue(1'b1, 2'b10, 1'b0, 6'h08, 32'hDEADBEEF);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 2 || err !== 1'b0) begin errors++; $display("FAIL sw_rsp: got lat %0d err %b want 2/0", lat, err); end
        checks++; if (nwr !== 1 || wr_cyc[0] !== 1) begin errors++; $display("FAIL sw_wr_count: got %0d@%0d want 1@1", nwr, wr_cyc[0]); end
        checks++; if ({wr_addr[0], wr_be[0], wr_data[0]} !== {4'd2, 4'b1111, 32'hDEADBEEF}) begin errors++;
            $display("FAIL sw_wr: got %h %b %h want 2 1111 deadbeef", wr_addr[0], wr_be[0], wr_data[0]); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL sw_rdata: got %h want 0", rdata); end
    endtask

    task automatic test_byte;
        issue(1'b1, 2'b00, 1'b0, 6'h0D, 32'h000000A5);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 2 || nwr !== 1) begin errors++; $display("FAIL sb_lat: got lat %0d nwr %0d want 2/1", lat, nwr); end
        checks++; if ({wr_addr[0], wr_be[0], wr_data[0]} !== {4'd3, 4'b0010, 32'h0000A500}) begin errors++;
            $display("FAIL sb_wr: got %h %b %h want 3 0010 0000a500", wr_addr[0], wr_be[0], wr_data[0]); end
        issue(1'b0, 2'b00, 1'b1, 6'h0D, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 3 || err !== 1'b0 || nrd !== 1 || nwr !== 0) begin errors++;
            $display("FAIL lb_s_timing: got lat %0d err %b nrd %0d nwr %0d want 3/0/1/0", lat, err, nrd, nwr); end
        checks++; if (rdata !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb_s_data: got %h want ffffffa5", rdata); end
        issue(1'b0, 2'b00, 1'b0, 6'h0D, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (rdata !== 32'h000000A5 || lat !== 3) begin errors++; $display("FAIL lb_u: got %h lat %0d want 000000a5/3", rdata, lat); end
    endtask

    task automatic test_aligned_loads;
        issue(1'b0, 2'b01, 1'b1, 6'h08, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_s: got %h want ffffbeef", rdata); end
        issue(1'b0, 2'b01, 1'b0, 6'h0A, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (rdata !== 32'h0000DEAD) begin errors++; $display("FAIL lh_u: got %h want 0000dead", rdata); end
        issue(1'b0, 2'b00, 1'b1, 6'h0B, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (rdata !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_hi: got %h want ffffffde", rdata); end
        issue(1'b0, 2'b10, 1'b1, 6'h08, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (rdata !== 32'hDEADBEEF || lat !== 3) begin errors++; $display("FAIL lw: got %h lat %0d want deadbeef/3", rdata, lat); end
    endtask

`ifdef MAU_MISALIGNED_SPLIT_EN
    task automatic test_split;
        issue(1'b1, 2'b01, 1'b0, 6'h0F, 32'h00008001);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 3 || err !== 1'b0 || nwr !== 2) begin errors++;
            $display("FAIL sh_split_rsp: got lat %0d err %b nwr %0d want 3/0/2", lat, err, nwr); end
        checks++; if ({wr_addr[0], wr_be[0], wr_data[0]} !== {4'd3, 4'b1000, 32'h01000000}) begin errors++;
            $display("FAIL sh_split_w0: got %h %b %h want 3 1000 01000000", wr_addr[0], wr_be[0], wr_data[0]); end
        checks++; if ({wr_addr[1], wr_be[1], wr_data[1]} !== {4'd4, 4'b0001, 32'h00000080}) begin errors++;
            $display("FAIL sh_split_w1: got %h %b %h want 4 0001 00000080", wr_addr[1], wr_be[1], wr_data[1]); end
        issue(1'b0, 2'b01, 1'b1, 6'h0F, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 4 || nrd !== 2) begin errors++; $display("FAIL lh_split_lat: got lat %0d nrd %0d want 4/2", lat, nrd); end
        checks++; if (rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_split_data: got %h want ffff8001", rdata); end
        issue(1'b1, 2'b10, 1'b0, 6'h3E, 32'h11223344);
        wait_rsp(lat, err, rdata);
        checks++; if ({wr_addr[0], wr_be[0], wr_data[0]} !== {4'd15, 4'b1100, 32'h33440000}) begin errors++;
            $display("FAIL sw_wrap_w0: got %h %b %h want f 1100 33440000", wr_addr[0], wr_be[0], wr_data[0]); end
        checks++; if ({wr_addr[1], wr_be[1], wr_data[1]} !== {4'd0, 4'b0011, 32'h00001122}) begin errors++;
            $display("FAIL sw_wrap_w1: got %h %b %h want 0 0011 00001122", wr_addr[1], wr_be[1], wr_data[1]); end
        issue(1'b1, 2'b01, 1'b0, 6'h0D, 32'h0000BEEF);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 2 || nwr !== 1 || wr_be[0] !== 4'b0110 || wr_data[0] !== 32'h00BEEF00) begin errors++;
            $display("FAIL sh_mis_single: got lat %0d nwr %0d be %b data %h want 2/1/0110/00beef00", lat, nwr, wr_be[0], wr_data[0]); end
    endtask
`else
    task automatic test_misaligned;
        issue(1'b1, 2'b10, 1'b0, 6'h3E, 32'h11223344);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 1 || err !== 1'b1 || nwr !== 0) begin errors++;
            $display("FAIL sw_mis_err: got lat %0d err %b nwr %0d want 1/1/0", lat, err, nwr); end
        issue(1'b0, 2'b01, 1'b1, 6'h0F, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 1 || err !== 1'b1 || nrd !== 0 || rdata !== 32'd0) begin errors++;
            $display("FAIL lh_mis_err: got lat %0d err %b nrd %0d data %h want 1/1/0/0", lat, err, nrd, rdata); end
    endtask
`endif

    task automatic test_reserved;
        issue(1'b0, 2'b11, 1'b0, 6'h04, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 1 || err !== 1'b1 || nrd !== 0 || rdata !== 32'd0) begin errors++;
            $display("FAIL rsv_err: got lat %0d err %b nrd %0d data %h want 1/1/0/0", lat, err, nrd, rdata); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsv_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 6'h10; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_we = 1'b0;
        @(negedge clk);
        checks++; if ({req_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL b2b_busy: got %b want 00", {req_ready, rsp_valid}); end
        @(negedge clk);
        checks++; if ({req_ready, rsp_valid, rsp_err} !== 3'b110) begin errors++; $display("FAIL b2b_rsp: got %b want 110", {req_ready, rsp_valid, rsp_err}); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 3 || rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_load: got lat %0d data %h want 3/12345678", lat, rdata); end
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 2'b01, 1'b1, 6'h0F, 32'd0);
`ifdef MAU_MISALIGNED_SPLIT_EN
        repeat (2) @(negedge clk);
`else
        @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        checks++; if ({req_ready, rsp_valid, rf_rd_en, rf_wr_en} !== 4'b1000) begin errors++;
            $display("FAIL rst_mid_ctrl: got %b want 1000", {req_ready, rsp_valid, rf_rd_en, rf_wr_en}); end
        checks++; if ({rsp_rdata, rf_rd_addr} !== 36'd0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", {rsp_rdata, rf_rd_addr}); end
        @(negedge clk);
        rst_n = 1'b1;
        nrd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || rf_rd_en) nrd++;
        end
        checks++; if (nrd !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", nrd); end
        issue(1'b0, 2'b10, 1'b0, 6'h08, 32'd0);
        wait_rsp(lat, err, rdata);
        checks++; if (lat !== 3 || err !== 1'b0 || rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL rst_mid_next: got lat %0d err %b data %h want 3/0/deadbeef", lat, err, rdata); end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_byte;
        test_aligned_loads;
`ifdef MAU_MISALIGNED_SPLIT_EN
        test_split;
`else
        test_misaligned;
`endif
        test_reserved;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
